// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 frame controller: state encodings,
// modulus constants and the single-bit residue update rule.
package mod5_pkg;

    localparam int unsigned MOD   = 5;
    localparam int unsigned RES_W = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } ctrl_state_e;

    typedef enum logic [RES_W-1:0] {
        ResR0 = 3'd0,
        ResR1 = 3'd1,
        ResR2 = 3'd2,
        ResR3 = 3'd3,
        ResR4 = 3'd4
    } res_state_e;

    // (2*r + b) mod 5 as a lookup, so no multiplier or divider is needed.
    function automatic res_state_e res_step(input res_state_e r, input logic b);
        case (r)
            ResR0:   res_step = b ? ResR1 : ResR0;
            ResR1:   res_step = b ? ResR3 : ResR2;
            ResR2:   res_step = b ? ResR0 : ResR4;
            ResR3:   res_step = b ? ResR2 : ResR1;
            ResR4:   res_step = b ? ResR4 : ResR3;
            default: res_step = ResR0;
        endcase
    endfunction

endpackage

// File: rtl/mod5_residue.sv
// Serial mod-5 residue tracker: consumes one bit per enabled cycle, MSB first.
module mod5_residue
    import mod5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             in_bit,
    output logic [RES_W-1:0] residue
);

    res_state_e res_q, res_d;

    // Next residue: clear wins over a shift step.
    always_comb begin
        res_d = res_q;
        if (clr) begin
            res_d = ResR0;
        end else if (en) begin
            res_d = res_step(res_q, in_bit);
        end
    end

    // Residue register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_q <= ResR0;
        end else begin
            res_q <= res_d;
        end
    end

    assign residue = res_q;

endmodule

// File: rtl/mod5_frame_ctrl.sv
// Frame controller: accepts a frame, shifts it MSB first through the mod-5
// residue tracker, then holds the result until consumed.
module mod5_frame_ctrl
    import mod5_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned LENW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [LENW-1:0]  in_len,
    input  logic             abort,
    output logic             ser_en,
    output logic             ser_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_div,
    output logic [RES_W-1:0] out_res,
    output logic             busy
);

    ctrl_state_e      state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic [LENW-1:0]  len_clamped;
    logic [LENW-1:0]  bit_idx;
    logic [W-1:0]     data_shifted;
    logic             res_clr;
    logic             res_en;
    logic [RES_W-1:0] residue;

    assign len_clamped  = (32'(in_len) > W) ? LENW'(W) : in_len;
    assign bit_idx      = cnt_q - LENW'(1);
    assign data_shifted = data_q >> bit_idx;

    // Next-state and output decode; abort overrides everything but reset.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        res_clr   = 1'b0;
        res_en    = 1'b0;
        in_ready  = 1'b0;
        ser_en    = 1'b0;
        ser_bit   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = len_clamped;
                    res_clr = 1'b1;
                    state_d = (len_clamped != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                ser_en  = 1'b1;
                ser_bit = data_shifted[0];
                res_en  = 1'b1;
                cnt_d   = cnt_q - LENW'(1);
                if (cnt_q == LENW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d = StIdle;
            data_d  = '0;
            cnt_d   = '0;
            res_clr = 1'b1;
            res_en  = 1'b0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    mod5_residue u_residue (
        .clk     (clk),
        .rst     (rst),
        .clr     (res_clr),
        .en      (res_en),
        .in_bit  (ser_bit),
        .residue (residue)
    );

    // Result is only presented while a frame sits in DONE.
    assign out_res = out_valid ? residue : '0;
    assign out_div = out_valid && (residue == '0);
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mod5_frame_ctrl.sv
// Randomised bench for mod5_frame_ctrl against an arithmetic reference model.
module tb_mod5_frame_ctrl;

    localparam int unsigned W    = 8;
    localparam int unsigned LENW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [LENW-1:0] in_len;
    logic            abort;
    logic            ser_en;
    logic            ser_bit;
    logic            out_valid;
    logic            out_ready;
    logic            out_div;
    logic [2:0]      out_res;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod5_frame_ctrl #(.W(W), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .abort     (abort),
        .ser_en    (ser_en),
        .ser_bit   (ser_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_div   (out_div),
        .out_res   (out_res),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned eff_len(input logic [LENW-1:0] l);
        return (int'(l) > int'(W)) ? W : int'(l);
    endfunction

    function automatic int unsigned frame_val(input logic [W-1:0] d, input logic [LENW-1:0] l);
        int unsigned n;
        n = eff_len(l);
        return int'(d) & ((32'd1 << n) - 1);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, in_ready, 1);
        check_eq({tag, "_ovalid"}, out_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_seren"}, ser_en, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, in_ready, 1);
        check_eq({tag, "_ovalid"}, out_valid, 0);
        check_eq({tag, "_div"}, out_div, 0);
        check_eq({tag, "_res"}, out_res, 0);
        check_eq({tag, "_seren"}, ser_en, 0);
        check_eq({tag, "_serbit"}, ser_bit, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // Offer a frame in IDLE and take the accept edge.
    task automatic accept(input logic [W-1:0] d, input logic [LENW-1:0] l);
        check_eq("acc_ready", in_ready, 1);
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Check n shift cycles of value v whose top bit index is top, with junk on ignored inputs.
    task automatic shift_bits(input int unsigned v, input int top, input int n);
        for (int i = top; i > top - n; i--) begin
            check_eq("sh_en", ser_en, 1);
            check_eq("sh_bit", ser_bit, (v >> i) & 1);
            check_eq("sh_ovalid", out_valid, 0);
            check_eq("sh_ready", in_ready, 0);
            check_eq("sh_busy", busy, 1);
            in_valid  = 1'($urandom % 2);
            in_data   = W'($urandom);
            in_len    = LENW'($urandom);
            out_ready = 1'($urandom % 2);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [W-1:0] d, input logic [LENW-1:0] l, input int hold);
        int unsigned n, v, r;
        n = eff_len(l);
        v = frame_val(d, l);
        r = v % 5;
        accept(d, l);
        shift_bits(v, int'(n) - 1, int'(n));
        check_eq("done_ovalid", out_valid, 1);
        check_eq("done_seren", ser_en, 0);
        check_eq("done_res", out_res, r);
        check_eq("done_div", out_div, (r == 0) ? 1 : 0);
        check_eq("done_ready", in_ready, 0);
        check_eq("done_busy", busy, 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_len   = LENW'($urandom);
            step();
            check_eq("hold_ovalid", out_valid, 1);
            check_eq("hold_res", out_res, r);
            check_eq("hold_div", out_div, (r == 0) ? 1 : 0);
            check_eq("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_idle("ret");
    endtask

    task automatic run_abort(input logic [W-1:0] d, input logic [LENW-1:0] l, input int k);
        int unsigned n, v;
        n = eff_len(l);
        v = frame_val(d, l);
        accept(d, l);
        shift_bits(v, int'(n) - 1, k);
        abort = 1'b1;
        step();
        check_idle("abort");
        // Abort must also beat a frame offered in IDLE.
        in_valid = 1'b1;
        in_data  = W'($urandom);
        in_len   = LENW'($urandom);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle("abort_prio");
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("abort_noval", out_valid, 0);
            check_eq("abort_noshift", ser_en, 0);
        end
    endtask

    task automatic run_reset(input logic [W-1:0] d, input logic [LENW-1:0] l, input int k);
        int unsigned n, v;
        n = eff_len(l);
        v = frame_val(d, l);
        accept(d, l);
        shift_bits(v, int'(n) - 1, k);
        rst   = 1'b0;
        abort = 1'($urandom % 2);
        step();
        rst   = 1'b1;
        abort = 1'b0;
        check_reset_outputs("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned sel, n;
        logic [W-1:0]    d;
        logic [LENW-1:0] l;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_outputs("por");
        rst = 1'b1;
        step();

        run_frame(8'b0001_0100, 4'd5, 0);
        run_frame(8'b0000_0111, 4'd3, 1);
        run_frame(8'hA5, 4'd0, 0);
        run_frame(8'hFF, 4'd15, 4);
        run_abort(8'b0001_0100, 4'd5, 2);
        run_frame(8'b0000_1010, 4'd4, 0);
        run_reset(8'b0001_0100, 4'd5, 2);
        run_reset(8'b0000_0111, 4'd3, 3);
        run_frame(8'b0000_0111, 4'd3, 0);

        for (int it = 0; it < 80; it++) begin
            d   = W'($urandom);
            l   = LENW'($urandom);
            n   = eff_len(l);
            sel = $urandom % 8;
            if (sel == 0 && n > 0) begin
                run_abort(d, l, int'($urandom % n));
            end else if (sel == 1) begin
                run_reset(d, l, int'($urandom % (n + 1)));
            end else begin
                run_frame(d, l, int'($urandom % 4));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod5_frame_ctrl.md
MOD5_FRAME_CTRL -- requirements
Module: mod5_frame_ctrl

Interface
REQ-001 Parameter W, default 8, maximum frame length in bits.
REQ-002 Parameter LENW, default 4, width of the length field; SHALL hold values 0..W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset: state clears on the rising clk edge when rst=0.
REQ-005 in_valid  input  1  frame offered.
REQ-006 in_ready  output  1  controller can accept a frame.
REQ-007 in_data  input  W  frame bits; in_data[in_len-1] is the MSB and is sent first.
REQ-008 in_len  input  LENW  number of frame bits.
REQ-009 abort  input  1  discard the current frame.
REQ-010 ser_en  output  1  a bit is being shifted this cycle (observability).
REQ-011 ser_bit  output  1  bit being shifted this cycle.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed.
REQ-014 out_div  output  1  frame value divisible by 5.
REQ-015 out_res  output  3  frame value mod 5.
REQ-016 busy  output  1  controller is not in IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-018 IDLE: in_ready=1; on an edge with in_valid=1, the block SHALL latch in_data and in_len, clear the residue and load cnt=min(in_len,W).
REQ-019 On acceptance, next state SHALL be SHIFT if the loaded cnt>0, else DONE.
REQ-020 in_len>W SHALL be clamped to W; only in_data[W-1:0] is used.
REQ-021 SHIFT: each cycle ser_en=1 and ser_bit=data[cnt-1]; at the edge the residue becomes (2*r+bit) mod 5 and cnt decrements.
REQ-022 When cnt=1 at an edge in SHIFT, next state SHALL be DONE.
REQ-023 Latency: for len>0, out_valid SHALL first be high in the cycle after the len-th shift edge (len+1 cycles after the accept edge); for len=0, in the cycle after the accept edge.
REQ-024 DONE: out_valid=1, out_res=residue, out_div=(residue==0); these SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-025 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-026 abort=1 at an edge SHALL force IDLE from any state, discard data and result, and produce no out_valid.
REQ-027 Priority SHALL be rst > abort > in_valid or out_ready.
REQ-028 out_ready outside DONE SHALL have no effect.
REQ-029 ser_en and out_valid SHALL never be high in the same cycle.
REQ-030 busy SHALL be 1 in SHIFT and DONE.
REQ-031 The residue SHALL always be in 0..4 and SHALL never use a full-width multiply.

Reset
REQ-032 On an edge with rst=0, from any state including mid-SHIFT and DONE: state=IDLE, residue=0, cnt=0.
REQ-033 The cycle after that reset edge: in_ready=1, out_valid=0, out_div=0, out_res=0, ser_en=0, ser_bit=0, busy=0.
REQ-034 A result pending at reset SHALL be lost.

Structure
REQ-035 A shared package (mod5_pkg) SHALL hold the state encodings, MOD=5 and RES_W=3.
REQ-036 Sub-module mod5_residue (clk, rst, clr, en, bit, residue[2:0]) SHALL hold the serial mod-5 residue FSM with states R0..R4.
REQ-037 mod5_frame_ctrl SHALL sequence mod5_residue through clr and en.

Verification
REQ-038 data=10100b, len=5 -> five ser_en cycles with bits 1,0,1,0,0; out_valid at accept+6; out_div=1, out_res=0.
REQ-039 data=111b, len=3 -> out_div=0, out_res=2; out_valid at accept+4.
REQ-040 len=0 -> no ser_en; out_valid in the next cycle with out_div=1, out_res=0.
REQ-041 data=0xFF, len=15 (clamped to 8) -> out_div=1, out_res=0; hold out_ready=0 for 4 cycles while driving in_valid=1 -> outputs stable, in_ready=0, frame not accepted; out_ready=1 -> IDLE next cycle.
REQ-042 abort after 2 shifts of 10100b -> IDLE, no out_valid; then 1010b, len=4 -> out_div=1, out_res=0.
REQ-043 rst=0 mid-SHIFT (and again in DONE) -> all outputs at reset values in the next cycle; a following frame 111b gives out_res=2.
